shift_reg_reader: RTL and testbench



---
 rtl/shift_reg_reader.sv | 207 ++++++++++++++++++++
 tb/tb_shift_reg_reader.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_reg_reader.sv
// -----------------------------------------------------------------------------
// shift_reg_reader
//
// Parallel-in/serial-out reader for a 74HC165-style input shift register. It is
// the receive-side counterpart of the 595-style ShiftReg output driver and uses
// the same i_Enable / o_Ready handshake.
//
// A frame is: parallel load (SH/LD low), settle, then N_BITS shift periods.
// Each shift period has a low half, which ends by sampling QH, and a high half,
// whose rising SRCLK edge makes the device present the next bit. The first bit
// sampled is the device's H bit and ends up as the MSB of o_Data.
//
// Parameters:
//   N_BITS   bits captured per frame (1..32)
//   CLK_DIV  system clocks per SRCLK half-period and per load/settle phase;
//            must be >= 3 so that QH has crossed the synchronizer before sampling
//
// Ports:
//   i_clk     system clock (48 MHz)
//   i_rst     asynchronous reset, active high
//   i_Enable  start request, accepted only while o_Ready=1
//   o_Ready   idle and able to accept i_Enable (also high in the DONE cycle)
//   o_Data    last captured word, MSB = first bit shifted out
//   o_Valid   one-cycle pulse when o_Data updates
//   o_SHLD    SH/LD to the device, low = parallel load
//   o_SRCLK   shift clock to the device, shifts on the rising edge
//   i_SER     QH from the device, asynchronous to i_clk
//
// Build option:
//   SHIFTREG_READER_CHANGE_EN  when defined, o_Valid pulses only if the newly
//                              captured word differs from the current o_Data.
//                              o_Data and o_Ready timing are unaffected.
// -----------------------------------------------------------------------------
module shift_reg_reader #(
  parameter int unsigned N_BITS  = 8,
  parameter int unsigned CLK_DIV = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_Enable,
  output logic              o_Ready,
  output logic [N_BITS-1:0] o_Data,
  output logic              o_Valid,
  output logic              o_SHLD,
  output logic              o_SRCLK,
  input  logic              i_SER
);

  localparam int unsigned PhaseW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BitW   = $clog2(N_BITS + 1);

  localparam logic [PhaseW-1:0] PhaseLast = PhaseW'(CLK_DIV - 1);
  localparam logic [PhaseW-1:0] PhaseOne  = PhaseW'(1);
  localparam logic [BitW-1:0]   BitsTotal = BitW'(N_BITS);
  localparam logic [BitW-1:0]   BitOne    = BitW'(1);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StSettle,
    StShiftLo,
    StShiftHi,
    StDone
  } state_e;

  state_e              state_q;
  logic [PhaseW-1:0]   phase_q, phase_d;
  logic [BitW-1:0]     bit_cnt_q, bit_cnt_inc;
  logic [N_BITS-1:0]   cap_q, cap_d;
  logic [N_BITS-1:0]   data_q;
  logic                ready_q, valid_q, shld_q, srclk_q;
  logic                ser_meta_q, ser_sync_q;
  logic                busy, tick, new_valid;

  // ---------------------------------------------------------------------------
  // QH synchronizer: QH changes relative to SRCLK, which the device sees through
  // board wiring, so it is treated as fully asynchronous here.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ser_meta_q <= 1'b0;
      ser_sync_q <= 1'b0;
    end else begin
      ser_meta_q <= i_SER;
      ser_sync_q <= ser_meta_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Phase counter and datapath helpers
  // ---------------------------------------------------------------------------
  always_comb begin
    busy = (state_q == StLoad) || (state_q == StSettle) ||
           (state_q == StShiftLo) || (state_q == StShiftHi);
    tick = busy && (phase_q == PhaseLast);
    // The counter restarts on every tick so each timed state lasts CLK_DIV cycles.
    phase_d = (busy && !tick) ? (phase_q + PhaseOne) : '0;

    bit_cnt_inc = bit_cnt_q + BitOne;

    // Left shift: the first sampled bit travels up to the MSB.
    cap_d = (cap_q << 1) | N_BITS'(ser_sync_q);

`ifdef SHIFTREG_READER_CHANGE_EN
    // o_Data still holds the previous word (reset value 0 for the first frame).
    new_valid = (cap_q != data_q);
`else
    new_valid = 1'b1;
`endif
  end

  // ---------------------------------------------------------------------------
  // Frame FSM. All outputs are registered and set on the transition into the
  // state that owns them, so SH/LD and SRCLK never toggle in the same cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= StIdle;
      phase_q   <= '0;
      bit_cnt_q <= '0;
      cap_q     <= '0;
      data_q    <= '0;
      ready_q   <= 1'b1;
      valid_q   <= 1'b0;
      shld_q    <= 1'b1;
      srclk_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      valid_q <= 1'b0;

      case (state_q)
        StIdle: begin
          if (i_Enable) begin
            state_q <= StLoad;
            ready_q <= 1'b0;
            shld_q  <= 1'b0;
          end
        end

        StLoad: begin
          if (tick) begin
            state_q <= StSettle;
            shld_q  <= 1'b1;
          end
        end

        StSettle: begin
          if (tick) begin
            state_q   <= StShiftLo;
            bit_cnt_q <= '0;
          end
        end

        StShiftLo: begin
          // Sample at the end of the low half; QH has been stable for at least
          // CLK_DIV cycles by now, which covers the synchronizer delay.
          if (tick) begin
            cap_q   <= cap_d;
            state_q <= StShiftHi;
            srclk_q <= 1'b1;
          end
        end

        StShiftHi: begin
          if (tick) begin
            bit_cnt_q <= bit_cnt_inc;
            srclk_q   <= 1'b0;
            if (bit_cnt_inc == BitsTotal) begin
              state_q <= StDone;
              ready_q <= 1'b1;
              data_q  <= cap_q;
              valid_q <= new_valid;
            end else begin
              state_q <= StShiftLo;
            end
          end
        end

        StDone: begin
          // o_Ready is already high here, so a held i_Enable chains frames
          // back-to-back without passing through IDLE.
          if (i_Enable) begin
            state_q <= StLoad;
            ready_q <= 1'b0;
            shld_q  <= 1'b0;
          end else begin
            state_q <= StIdle;
          end
        end

        default: begin
          state_q <= StIdle;
          ready_q <= 1'b1;
          shld_q  <= 1'b1;
          srclk_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_Ready = ready_q;
  assign o_Data  = data_q;
  assign o_Valid = valid_q;
  assign o_SHLD  = shld_q;
  assign o_SRCLK = srclk_q;

endmodule

// File: tb/tb_shift_reg_reader.sv
// -----------------------------------------------------------------------------
// tb_shift_reg_reader
//
// Directed bench for shift_reg_reader. Two instances share clock and reset:
// A uses the defaults (8 bits, CLK_DIV=4), B uses 16 bits with CLK_DIV=3.
// Each instance drives a behavioural 74HC165 model. Expected values are
// hand-computed constants; the watch task only gathers observations.
// -----------------------------------------------------------------------------
module tb_shift_reg_reader;

  localparam int unsigned NA = 8;
  localparam int unsigned DA = 4;
  localparam int unsigned NB = 16;
  localparam int unsigned DB = 3;

`ifdef SHIFTREG_READER_CHANGE_EN
  localparam bit ChangeEn = 1'b1;
`else
  localparam bit ChangeEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          a_en = 1'b0;
  logic          a_ready, a_valid, a_shld, a_srclk, a_ser;
  logic [NA-1:0] a_data;
  logic          b_en = 1'b0;
  logic          b_ready, b_valid, b_shld, b_srclk, b_ser;
  logic [NB-1:0] b_data;

  shift_reg_reader #(.N_BITS(NA), .CLK_DIV(DA)) u_dut_a (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_Enable (a_en),
    .o_Ready  (a_ready),
    .o_Data   (a_data),
    .o_Valid  (a_valid),
    .o_SHLD   (a_shld),
    .o_SRCLK  (a_srclk),
    .i_SER    (a_ser)
  );

  shift_reg_reader #(.N_BITS(NB), .CLK_DIV(DB)) u_dut_b (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_Enable (b_en),
    .o_Ready  (b_ready),
    .o_Data   (b_data),
    .o_Valid  (b_valid),
    .o_SHLD   (b_shld),
    .o_SRCLK  (b_srclk),
    .i_SER    (b_ser)
  );

  // 74HC165 models: parallel load while SH/LD is low, shift toward QH on the
  // rising SRCLK edge with SER tied low.
  logic [NA-1:0] pat_a = '0;
  logic [NA-1:0] mdl_a = '0;
  logic [NB-1:0] pat_b = '0;
  logic [NB-1:0] mdl_b = '0;

  always @(negedge a_shld or posedge a_srclk) begin
    if (!a_shld) mdl_a <= pat_a;
    else         mdl_a <= mdl_a << 1;
  end
  assign a_ser = mdl_a[NA-1];

  always @(negedge b_shld or posedge b_srclk) begin
    if (!b_shld) mdl_b <= pat_b;
    else         mdl_b <= mdl_b << 1;
  end
  assign b_ser = mdl_b[NB-1];

  // Monitor mux so one watch task serves both instances.
  bit          mon_sel = 1'b0;
  logic [31:0] m_data;
  logic        m_ready, m_valid, m_shld, m_srclk;
  always_comb begin
    m_data  = mon_sel ? 32'(b_data)  : 32'(a_data);
    m_ready = mon_sel ? b_ready : a_ready;
    m_valid = mon_sel ? b_valid : a_valid;
    m_shld  = mon_sel ? b_shld  : a_shld;
    m_srclk = mon_sel ? b_srclk : a_srclk;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic set_en(input bit sel, input logic v);
    if (sel) b_en = v;
    else     a_en = v;
  endtask

  // Observations gathered by watch (cycle indices relative to the call).
  int          w_nfall, w_fall1, w_fall2, w_nvalid, w_v1, w_v2;
  int          w_rises, w_shld_low, w_rdy_bad;
  logic [31:0] w_d1, w_d2;

  // Called just after a falling clock edge. Optionally raises enable for the
  // next rising edge, then samples every falling edge for 'cycles' cycles.
  // Enable is kept high when 'hold' is set, or pulsed at index 'pulse_at'.
  task automatic watch(input bit sel, input bit start, input int cycles, input bit hold,
                       input int pulse_at, input logic [NA-1:0] pat_next);
    bit prev_shld = 1'b1;
    bit prev_srclk = 1'b0;
    mon_sel = sel;
    w_nfall = 0; w_fall1 = -1; w_fall2 = -1; w_nvalid = 0; w_v1 = -1; w_v2 = -1;
    w_rises = 0; w_shld_low = 0; w_rdy_bad = 0; w_d1 = '0; w_d2 = '0;
    if (start) set_en(sel, 1'b1);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (prev_shld && !m_shld) begin
        w_nfall++;
        if (w_nfall == 1)      w_fall1 = i;
        else if (w_nfall == 2) w_fall2 = i;
      end
      if (!m_shld) w_shld_low++;
      if (!prev_srclk && m_srclk) w_rises++;
      if (m_valid) begin
        w_nvalid++;
        if (w_nvalid == 1) begin
          w_v1 = i;
          w_d1 = m_data;
          if (!sel) pat_a = pat_next;
        end else if (w_nvalid == 2) begin
          w_v2 = i;
          w_d2 = m_data;
        end
      end
      if (m_ready != m_valid) w_rdy_bad++;
      prev_shld  = m_shld;
      prev_srclk = m_srclk;
      set_en(sel, hold || (i == pulse_at));
    end
  endtask

  logic [NA-1:0] t6_pats [5] = '{8'h3C, 8'h3C, 8'h00, 8'h00, 8'h01};

  initial begin
    int          rises;
    bit          prev;
    logic [NA-1:0] prev_data;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(a_ready), 32'd1);
    check("rst_valid", 32'(a_valid), 32'd0);
    check("rst_data",  32'(a_data),  32'd0);
    check("rst_shld",  32'(a_shld),  32'd1);
    check("rst_srclk", 32'(a_srclk), 32'd0);
    check("rst_b_data", 32'(b_data), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single frame of 0xA5
    pat_a = 8'hA5;
    watch(1'b0, 1'b1, 100, 1'b0, -1, pat_a);
    check("t1_latency",  32'(w_v1 - w_fall1), 32'd72);
    check("t1_nvalid",   32'(w_nvalid),       32'd1);
    check("t1_data",     w_d1,                32'h A5);
    check("t1_rises",    32'(w_rises),        32'd8);
    check("t1_shld_low", 32'(w_shld_low),     32'd4);
    check("t1_ready",    32'(a_ready),        32'd1);

    // Enable held: 0x01 then 0x80 back-to-back
    pat_a = 8'h01;
    watch(1'b0, 1'b1, 150, 1'b1, -1, 8'h80);
    check("t2_nvalid",    32'(w_nvalid),       32'd2);
    check("t2_gap",       32'(w_v2 - w_v1),    32'd73);
    check("t2_shld_next", 32'(w_fall2 - w_v1), 32'd1);
    check("t2_data1",     w_d1,                32'h01);
    check("t2_data2",     w_d2,                32'h80);
    check("t2_ready_bad", 32'(w_rdy_bad),      32'd0);
    a_en = 1'b0;
    repeat (100) @(negedge clk);

    // Enable pulsed mid-frame is ignored
    pat_a = 8'h3C;
    watch(1'b0, 1'b1, 170, 1'b0, 19, pat_a);
    check("t3_nvalid",   32'(w_nvalid),   32'd1);
    check("t3_rises",    32'(w_rises),    32'd8);
    check("t3_shld_low", 32'(w_shld_low), 32'd4);
    check("t3_data",     32'(a_data),     32'h3C);

    // Reset after three SRCLK rising edges of 0xFF
    pat_a = 8'hFF;
    a_en = 1'b1;
    @(negedge clk);
    a_en = 1'b0;
    rises = 0;
    prev = 1'b0;
    for (int i = 0; i < 200 && rises < 3; i++) begin
      @(negedge clk);
      if (!prev && a_srclk) rises++;
      prev = a_srclk;
    end
    check("t4_wait_rises", 32'(rises), 32'd3);
    #2 rst = 1'b1;
    #1;
    check("t4_async_ready", 32'(a_ready), 32'd1);
    check("t4_async_valid", 32'(a_valid), 32'd0);
    check("t4_async_data",  32'(a_data),  32'd0);
    check("t4_async_shld",  32'(a_shld),  32'd1);
    check("t4_async_srclk", 32'(a_srclk), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    watch(1'b0, 1'b0, 40, 1'b0, -1, pat_a);
    check("t4_no_valid", 32'(w_nvalid), 32'd0);
    watch(1'b0, 1'b1, 100, 1'b0, -1, pat_a);
    check("t4_nvalid", 32'(w_nvalid), 32'd1);
    check("t4_data",   w_d1,          32'hFF);

    // 16-bit instance, CLK_DIV=3, pattern 0x8001
    pat_b = 16'h8001;
    watch(1'b1, 1'b1, 120, 1'b0, -1, pat_a);
    check("t5_latency", 32'(w_v1 - w_fall1), 32'd102);
    check("t5_nvalid",  32'(w_nvalid),       32'd1);
    check("t5_data",    w_d1,                32'h8001);
    check("t5_rises",   32'(w_rises),        32'd16);

    // Valid-on-change sequence (every frame pulses when the option is off)
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    prev_data = '0;
    for (int k = 0; k < 5; k++) begin
      pat_a = t6_pats[k];
      watch(1'b0, 1'b1, 90, 1'b0, -1, pat_a);
      check($sformatf("t6_f%0d_nvalid", k), 32'(w_nvalid),
            (!ChangeEn || (t6_pats[k] != prev_data)) ? 32'd1 : 32'd0);
      check($sformatf("t6_f%0d_data", k), 32'(a_data), 32'(t6_pats[k]));
      prev_data = t6_pats[k];
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
